// File: rtl/axi_wr_arbiter_rr.sv
// Round-robin AXI write arbiter: grants one burst per request, streams it from the
// granted channel's line buffer onto AW/W, and keeps a per-channel frame write pointer.
module axi_wr_arbiter_rr #(
    parameter int CH_NUM          = 5,
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int MEM_DQ_WIDTH    = 32,
    parameter int BURST_LEN       = 16,
    parameter int ADDR_STEP       = 128,
    parameter int FRAME_BURSTS    = 1050,
    parameter int BUF_AW          = 10
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [CH_NUM-1:0]                 ch_req,
    input  logic [CH_NUM-1:0]                 ch_fsync,
    input  logic [CH_NUM*CTRL_ADDR_WIDTH-1:0] ch_base_addr,
    input  logic [CH_NUM*MEM_DQ_WIDTH*8-1:0]  ch_rd_data,
    output logic [CH_NUM-1:0]                 buf_rd_en,
    output logic [BUF_AW-1:0]                 buf_rd_addr,
    output logic [CH_NUM-1:0]                 ch_done,
    output logic [CTRL_ADDR_WIDTH-1:0]        axi_awaddr,
    output logic [3:0]                        axi_awid,
    output logic [3:0]                        axi_awlen,
    output logic [2:0]                        axi_awsize,
    output logic [1:0]                        axi_awburst,
    output logic                              axi_awvalid,
    input  logic                              axi_awready,
    output logic [MEM_DQ_WIDTH*8-1:0]         axi_wdata,
    output logic [MEM_DQ_WIDTH-1:0]           axi_wstrb,
    output logic                              axi_wvalid,
    input  logic                              axi_wready,
    input  logic                              axi_wlast,
    input  logic [3:0]                        axi_bid,
    output logic                              busy
);

    localparam int DW  = MEM_DQ_WIDTH * 8;
    localparam int AW  = CTRL_ADDR_WIDTH;
    localparam int GW  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int BCW = $clog2(BURST_LEN) + 1;
    localparam int FCW = $clog2(FRAME_BURSTS + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARB  = 3'd1;
    localparam logic [2:0] S_AW   = 3'd2;
    localparam logic [2:0] S_W    = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     rr_q, rr_d;
    logic [BCW-1:0]    beat_cnt_q, beat_cnt_d;
    logic              init_q, init_d;
    logic [CH_NUM-1:0] fsync_pend_q, fsync_pend_d;
    logic [AW-1:0]     wr_ptr_q [CH_NUM];
    logic [AW-1:0]     wr_ptr_d [CH_NUM];
    logic [FCW-1:0]    burst_cnt_q [CH_NUM];
    logic [FCW-1:0]    burst_cnt_d [CH_NUM];

    logic           aw_hs;
    logic           w_hs;
    logic           last_beat;
    logic           rd_fire;
    logic [BCW-1:0] beat_nxt;
    logic           arb_found;
    logic [GW-1:0]  arb_pick;
    logic           unused_bid;

    assign unused_bid = ^axi_bid;

    assign aw_hs     = (state_q == S_AW) && axi_awready;
    assign w_hs      = (state_q == S_W) && axi_wready;
    assign beat_nxt  = beat_cnt_q + BCW'(1);
    // The internal beat count ends the burst even if the controller never raises wlast.
    assign last_beat = w_hs && (axi_wlast || (beat_cnt_q == BCW'(BURST_LEN - 1)));
    assign rd_fire   = aw_hs || (w_hs && !last_beat);

    assign buf_rd_addr = (w_hs && !last_beat) ? BUF_AW'(beat_nxt) : '0;

    assign axi_awvalid = (state_q == S_AW);
    assign axi_wvalid  = (state_q == S_W);
    assign busy        = (state_q != S_IDLE);
    assign axi_awid    = 4'(grant_q);
    assign axi_awlen   = 4'(BURST_LEN - 1);
    assign axi_awsize  = 3'b101;
    assign axi_awburst = 2'b01;
    assign axi_wstrb   = '1;

    // Round-robin search: channels above the last grant first, then wrap to the bottom.
    always_comb begin
        arb_found = 1'b0;
        arb_pick  = rr_q;
        for (int i = 0; i < CH_NUM; i++) begin
            if (!arb_found && ch_req[i] && (GW'(i) > rr_q)) begin
                arb_found = 1'b1;
                arb_pick  = GW'(i);
            end
        end
        for (int i = 0; i < CH_NUM; i++) begin
            if (!arb_found && ch_req[i] && (GW'(i) <= rr_q)) begin
                arb_found = 1'b1;
                arb_pick  = GW'(i);
            end
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        axi_awaddr = '0;
        axi_wdata  = '0;
        buf_rd_en  = '0;
        ch_done    = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (grant_q == GW'(k)) begin
                axi_awaddr   = wr_ptr_q[k];
                axi_wdata    = ch_rd_data[k*DW +: DW];
                buf_rd_en[k] = rd_fire;
                ch_done[k]   = (state_q == S_DONE);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            S_IDLE: if (|ch_req) state_d = S_ARB;
            S_ARB: begin
                if (arb_found) begin
                    grant_d = arb_pick;
                    rr_d    = arb_pick;
                    state_d = S_AW;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_AW: begin
                beat_cnt_d = '0;
                if (axi_awready) state_d = S_W;
            end
            S_W: begin
                if (w_hs) begin
                    beat_cnt_d = beat_nxt;
                    if (last_beat) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Frame pointers: a frame sync on the channel being served waits for DONE.
    always_comb begin
        init_d       = 1'b0;
        fsync_pend_d = fsync_pend_q;
        wr_ptr_d     = wr_ptr_q;
        burst_cnt_d  = burst_cnt_q;
        for (int k = 0; k < CH_NUM; k++) begin
            if (init_q) begin
                wr_ptr_d[k]     = ch_base_addr[k*AW +: AW];
                burst_cnt_d[k]  = '0;
                fsync_pend_d[k] = 1'b0;
            end else if ((state_q == S_DONE) && (grant_q == GW'(k))) begin
                fsync_pend_d[k] = 1'b0;
                if (fsync_pend_q[k] || ch_fsync[k] ||
                    (burst_cnt_q[k] == FCW'(FRAME_BURSTS - 1))) begin
                    wr_ptr_d[k]    = ch_base_addr[k*AW +: AW];
                    burst_cnt_d[k] = '0;
                end else begin
                    wr_ptr_d[k]    = wr_ptr_q[k] + AW'(ADDR_STEP);
                    burst_cnt_d[k] = burst_cnt_q[k] + FCW'(1);
                end
            end else if (ch_fsync[k]) begin
                if (((state_q == S_AW) || (state_q == S_W)) && (grant_q == GW'(k))) begin
                    fsync_pend_d[k] = 1'b1;
                end else begin
                    wr_ptr_d[k]    = ch_base_addr[k*AW +: AW];
                    burst_cnt_d[k] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            rr_q         <= GW'(CH_NUM - 1);
            beat_cnt_q   <= '0;
            fsync_pend_q <= '0;
            // NOTE: the base address is an input, not a constant, so pointers clear here
            // and init_q loads ch_base_addr on the first clock after release.
            init_q       <= 1'b1;
            for (int k = 0; k < CH_NUM; k++) begin
                wr_ptr_q[k]    <= '0;
                burst_cnt_q[k] <= '0;
            end
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_q         <= rr_d;
            beat_cnt_q   <= beat_cnt_d;
            fsync_pend_q <= fsync_pend_d;
            init_q       <= init_d;
            wr_ptr_q     <= wr_ptr_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_axi_wr_arbiter_rr.sv
// Directed bench for axi_wr_arbiter_rr: line-buffer model plus per-scenario tasks
// comparing AW/W traffic against hand-computed expectations.
module tb_axi_wr_arbiter_rr;

    localparam int CH   = 5;
    localparam int AW   = 28;
    localparam int DQ   = 32;
    localparam int DW   = DQ * 8;
    localparam int BL   = 16;
    localparam int STEP = 128;
    localparam int BAW  = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [CH-1:0]    ch_req, ch_fsync;
    logic [CH*AW-1:0] ch_base_addr;
    logic [CH*DW-1:0] ch_rd_data;
    logic [CH-1:0]    buf_rd_en, ch_done;
    logic [BAW-1:0]   buf_rd_addr;
    logic [AW-1:0]    axi_awaddr;
    logic [3:0]       axi_awid, axi_awlen, axi_bid;
    logic [2:0]       axi_awsize;
    logic [1:0]       axi_awburst;
    logic             axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_wlast, busy;
    logic [DW-1:0]    axi_wdata;
    logic [DQ-1:0]    axi_wstrb;

    logic [AW-1:0] base    [CH];
    logic [DW-1:0] rd_data [CH];
    logic [CH-1:0] rd_en_l;
    logic [BAW-1:0] rd_addr_l;

    int n_err = 0;
    int n_chk = 0;

    axi_wr_arbiter_rr #(
        .CH_NUM(CH), .CTRL_ADDR_WIDTH(AW), .MEM_DQ_WIDTH(DQ), .BURST_LEN(BL),
        .ADDR_STEP(STEP), .FRAME_BURSTS(1050), .BUF_AW(BAW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_fsync(ch_fsync),
        .ch_base_addr(ch_base_addr), .ch_rd_data(ch_rd_data),
        .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .ch_done(ch_done),
        .axi_awaddr(axi_awaddr), .axi_awid(axi_awid), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid),
        .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wlast(axi_wlast),
        .axi_bid(axi_bid), .busy(busy)
    );

    // Short-frame instance for the frame-wrap scenario.
    logic [CH-1:0]  fw_req, fw_rd_en, fw_done;
    logic [BAW-1:0] fw_rd_addr;
    logic [AW-1:0]  fw_awaddr;
    logic [3:0]     fw_awid, fw_awlen;
    logic [2:0]     fw_awsize;
    logic [1:0]     fw_awburst;
    logic           fw_awvalid, fw_wvalid, fw_busy;
    logic [DW-1:0]  fw_wdata;
    logic [DQ-1:0]  fw_wstrb;

    axi_wr_arbiter_rr #(
        .CH_NUM(CH), .CTRL_ADDR_WIDTH(AW), .MEM_DQ_WIDTH(DQ), .BURST_LEN(BL),
        .ADDR_STEP(STEP), .FRAME_BURSTS(3), .BUF_AW(BAW)
    ) dut_fw (
        .clk(clk), .rst_n(rst_n), .ch_req(fw_req), .ch_fsync({CH{1'b0}}),
        .ch_base_addr({(CH*AW){1'b0}}), .ch_rd_data({(CH*DW){1'b0}}),
        .buf_rd_en(fw_rd_en), .buf_rd_addr(fw_rd_addr), .ch_done(fw_done),
        .axi_awaddr(fw_awaddr), .axi_awid(fw_awid), .axi_awlen(fw_awlen),
        .axi_awsize(fw_awsize), .axi_awburst(fw_awburst), .axi_awvalid(fw_awvalid),
        .axi_awready(1'b1), .axi_wdata(fw_wdata), .axi_wstrb(fw_wstrb),
        .axi_wvalid(fw_wvalid), .axi_wready(1'b1), .axi_wlast(1'b0),
        .axi_bid(4'd0), .busy(fw_busy)
    );

    function automatic logic [DW-1:0] buf_word(input int k, input int a);
        logic [DW-1:0] w;
        w = '0;
        w[15:0]       = 16'(a);
        w[23:16]      = 8'(k);
        w[DW-1 -: 32] = 32'hA5A5_0000 | 32'(a);
        return w;
    endfunction

    always_comb begin
        ch_base_addr = '0;
        ch_rd_data   = '0;
        for (int k = 0; k < CH; k++) begin
            ch_base_addr[k*AW +: AW] = base[k];
            ch_rd_data[k*DW +: DW]   = rd_data[k];
        end
    end

    // Line-buffer model: read request latched mid-cycle, data returned on the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            rd_en_l   <= '0;
            rd_addr_l <= '0;
        end else begin
            rd_en_l   <= buf_rd_en;
            rd_addr_l <= buf_rd_addr;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CH; k++) rd_data[k] <= '0;
        end else begin
            for (int k = 0; k < CH; k++)
                if (rd_en_l[k]) rd_data[k] <= buf_word(k, int'(rd_addr_l));
        end
    end

    // Runs one burst to completion; reports what was seen, bounded by a cycle budget.
    task automatic run_burst(input int bp, input int fs_ch, input bit drop_req,
                             output int id, output logic [AW-1:0] addr, output int beats,
                             output int bad, output int dones, output bit to);
        int cyc = 0;
        int post = 0;
        bit got_aw = 0;
        bit fs_done = 0;
        bit fin = 0;
        bit drop_pend = 0;
        id = -1; addr = '0; beats = 0; bad = 0; dones = 0; to = 1'b0;
        while (!(fin && post >= 2) && cyc < 300) begin
            @(posedge clk); #1;
            axi_wready = (bp == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
            axi_wlast  = (beats == BL - 1);
            ch_fsync   = '0;
            if (fs_ch >= 0 && beats == 4 && !fs_done) begin
                ch_fsync = CH'(1 << fs_ch);
                fs_done  = 1'b1;
            end
            if (drop_pend) ch_req = '0;
            @(negedge clk);
            cyc++;
            if (fin) post++;
            if (axi_awvalid && axi_awready && !got_aw) begin
                id = int'(axi_awid);
                addr = axi_awaddr;
                got_aw = 1'b1;
                drop_pend = drop_req;
            end
            if (got_aw) begin
                if (buf_rd_en !== '0 && buf_rd_en !== CH'(1 << id)) bad++;
            end else if (buf_rd_en !== '0) begin
                bad++;
            end
            if (axi_wvalid && axi_wready) begin
                if (axi_wdata !== buf_word(id, beats)) bad++;
                beats++;
            end
            if (ch_done !== '0) begin
                dones++;
                if (!got_aw || ch_done !== CH'(1 << id)) bad++;
                fin = 1'b1;
            end
        end
        axi_wready = 1'b1;
        axi_wlast  = 1'b0;
        ch_fsync   = '0;
        to = !fin;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_chk++; if (axi_awvalid !== 1'b0) begin n_err++; $display("FAIL rst_awvalid: got %b want 0", axi_awvalid); end
        n_chk++; if (axi_wvalid !== 1'b0) begin n_err++; $display("FAIL rst_wvalid: got %b want 0", axi_wvalid); end
        n_chk++; if (buf_rd_en !== 5'b0) begin n_err++; $display("FAIL rst_rd_en: got %b want 0", buf_rd_en); end
        n_chk++; if (ch_done !== 5'b0) begin n_err++; $display("FAIL rst_ch_done: got %b want 0", ch_done); end
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_chk++; if (buf_rd_addr !== 10'd0) begin n_err++; $display("FAIL rst_rd_addr: got %0d want 0", buf_rd_addr); end
        n_chk++; if (axi_awlen !== 4'd15) begin n_err++; $display("FAIL awlen: got %0d want 15", axi_awlen); end
        n_chk++; if (axi_awsize !== 3'b101) begin n_err++; $display("FAIL awsize: got %b want 101", axi_awsize); end
        n_chk++; if (axi_awburst !== 2'b01) begin n_err++; $display("FAIL awburst: got %b want 01", axi_awburst); end
        n_chk++; if (axi_wstrb !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wstrb: got %h want ffffffff", axi_wstrb); end
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_single();
        int id, beats, bad, dones;
        logic [AW-1:0] addr;
        bit to;
        @(posedge clk); #1 ch_req = 5'b00100;
        run_burst(0, -1, 1'b0, id, addr, beats, bad, dones, to);
        n_chk++; if (to !== 1'b0) begin n_err++; $display("FAIL single1_timeout: got %b want 0", to); end
        n_chk++; if (id !== 2) begin n_err++; $display("FAIL single1_id: got %0d want 2", id); end
        n_chk++; if (addr !== 28'h100000) begin n_err++; $display("FAIL single1_addr: got %h want 100000", addr); end
        n_chk++; if (beats !== 16) begin n_err++; $display("FAIL single1_beats: got %0d want 16", beats); end
        n_chk++; if (bad !== 0) begin n_err++; $display("FAIL single1_data: got %0d bad beats want 0", bad); end
        n_chk++; if (dones !== 1) begin n_err++; $display("FAIL single1_done: got %0d pulses want 1", dones); end
        run_burst(0, -1, 1'b1, id, addr, beats, bad, dones, to);
        n_chk++; if (to !== 1'b0) begin n_err++; $display("FAIL single2_timeout: got %b want 0", to); end
        n_chk++; if (id !== 2) begin n_err++; $display("FAIL single2_id: got %0d want 2", id); end
        n_chk++; if (addr !== 28'h100080) begin n_err++; $display("FAIL single2_addr: got %h want 100080", addr); end
        n_chk++; if (beats !== 16) begin n_err++; $display("FAIL single2_beats: got %0d want 16", beats); end
        n_chk++; if (bad !== 0) begin n_err++; $display("FAIL single2_data: got %0d bad beats want 0", bad); end
        n_chk++; if (dones !== 1) begin n_err++; $display("FAIL single2_done: got %0d pulses want 1", dones); end
        repeat (4) @(negedge clk);
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_back_pressure();
        int id, beats, bad, dones;
        logic [AW-1:0] addr;
        bit to;
        @(posedge clk); #1 ch_req = 5'b00001;
        run_burst(1, -1, 1'b1, id, addr, beats, bad, dones, to);
        n_chk++; if (to !== 1'b0) begin n_err++; $display("FAIL bp_timeout: got %b want 0", to); end
        n_chk++; if (id !== 0) begin n_err++; $display("FAIL bp_id: got %0d want 0", id); end
        n_chk++; if (addr !== 28'h0) begin n_err++; $display("FAIL bp_addr: got %h want 0", addr); end
        n_chk++; if (beats !== 16) begin n_err++; $display("FAIL bp_beats: got %0d want 16", beats); end
        n_chk++; if (bad !== 0) begin n_err++; $display("FAIL bp_data: got %0d bad beats want 0", bad); end
        n_chk++; if (dones !== 1) begin n_err++; $display("FAIL bp_done: got %0d pulses want 1", dones); end
    endtask

    task automatic test_fsync();
        int id, beats, bad, dones;
        logic [AW-1:0] addr;
        bit to;
        // Idle fsync on ch2 (pointer at 0x100100) returns it to base.
        @(posedge clk); #1 ch_fsync = 5'b00100;
        @(posedge clk); #1 ch_fsync = 5'b00000; ch_req = 5'b00100;
        run_burst(0, -1, 1'b1, id, addr, beats, bad, dones, to);
        n_chk++; if (addr !== 28'h100000) begin n_err++; $display("FAIL fsync_idle_addr: got %h want 100000", addr); end
        n_chk++; if (id !== 2) begin n_err++; $display("FAIL fsync_idle_id: got %0d want 2", id); end
        @(posedge clk); #1 ch_req = 5'b00010;
        for (int i = 0; i < 4; i++) begin
            run_burst(0, -1, 1'b0, id, addr, beats, bad, dones, to);
            n_chk++; if (addr !== AW'(i * STEP)) begin n_err++; $display("FAIL fsync_pre%0d_addr: got %h want %h", i, addr, AW'(i * STEP)); end
            n_chk++; if (id !== 1) begin n_err++; $display("FAIL fsync_pre%0d_id: got %0d want 1", i, id); end
        end
        run_burst(0, 1, 1'b1, id, addr, beats, bad, dones, to);
        n_chk++; if (to !== 1'b0) begin n_err++; $display("FAIL fsync_mid_timeout: got %b want 0", to); end
        n_chk++; if (addr !== 28'h200) begin n_err++; $display("FAIL fsync_mid_addr: got %h want 200", addr); end
        n_chk++; if (beats !== 16) begin n_err++; $display("FAIL fsync_mid_beats: got %0d want 16", beats); end
        n_chk++; if (bad !== 0) begin n_err++; $display("FAIL fsync_mid_data: got %0d bad beats want 0", bad); end
        n_chk++; if (dones !== 1) begin n_err++; $display("FAIL fsync_mid_done: got %0d pulses want 1", dones); end
        @(posedge clk); #1 ch_req = 5'b00010;
        run_burst(0, -1, 1'b1, id, addr, beats, bad, dones, to);
        n_chk++; if (addr !== 28'h0) begin n_err++; $display("FAIL fsync_after_addr: got %h want 0", addr); end
        n_chk++; if (id !== 1) begin n_err++; $display("FAIL fsync_after_id: got %0d want 1", id); end
    endtask

    task automatic test_async_reset();
        int id, beats, bad, dones, hs;
        logic [AW-1:0] addr, ea;
        bit to, seen;
        hs = 0;
        @(posedge clk); #1 ch_req = 5'b00001;
        for (int c = 0; c < 100 && hs < 5; c++) begin
            @(negedge clk);
            if (axi_wvalid && axi_wready) hs++;
        end
        n_chk++; if (hs !== 5) begin n_err++; $display("FAIL arst_reach_w: got %0d beats want 5", hs); end
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (axi_awvalid !== 1'b0) begin n_err++; $display("FAIL arst_awvalid: got %b want 0", axi_awvalid); end
        n_chk++; if (axi_wvalid !== 1'b0) begin n_err++; $display("FAIL arst_wvalid: got %b want 0", axi_wvalid); end
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL arst_busy: got %b want 0", busy); end
        ch_req = 5'b11111;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ch_done !== 5'b0) seen = 1'b1;
        end
        n_chk++; if (seen !== 1'b0) begin n_err++; $display("FAIL arst_no_done: got %b want 0", seen); end
        #2 rst_n = 1'b1;
        // After release: pointers at base and the first grant goes to ch0.
        for (int i = 0; i < 10; i++) begin
            run_burst(0, -1, i == 9, id, addr, beats, bad, dones, to);
            ea = base[i % CH] + AW'((i / CH) * STEP);
            n_chk++; if (id !== i % CH) begin n_err++; $display("FAIL rr%0d_id: got %0d want %0d", i, id, i % CH); end
            n_chk++; if (addr !== ea) begin n_err++; $display("FAIL rr%0d_addr: got %h want %h", i, addr, ea); end
            n_chk++; if (beats !== 16) begin n_err++; $display("FAIL rr%0d_beats: got %0d want 16", i, beats); end
            n_chk++; if (bad !== 0) begin n_err++; $display("FAIL rr%0d_data: got %0d bad beats want 0", i, bad); end
            n_chk++; if (dones !== 1 || to !== 1'b0) begin n_err++; $display("FAIL rr%0d_done: got %0d pulses timeout=%b want 1/0", i, dones, to); end
        end
    endtask

    task automatic test_frame_wrap();
        logic [AW-1:0] got [4];
        logic [AW-1:0] want [4];
        int n = 0;
        want[0] = 28'd0; want[1] = 28'd128; want[2] = 28'd256; want[3] = 28'd0;
        for (int j = 0; j < 4; j++) got[j] = '1;
        @(posedge clk); #1 fw_req = 5'b00001;
        for (int c = 0; c < 400 && n < 4; c++) begin
            @(negedge clk);
            if (fw_awvalid) begin
                got[n] = fw_awaddr;
                n++;
            end
        end
        @(posedge clk); #1 fw_req = 5'b00000;
        n_chk++; if (n !== 4) begin n_err++; $display("FAIL fw_count: got %0d bursts want 4", n); end
        for (int j = 0; j < 4; j++) begin
            n_chk++; if (got[j] !== want[j]) begin n_err++; $display("FAIL fw%0d_addr: got %h want %h", j, got[j], want[j]); end
        end
    endtask

    initial begin
        ch_req = '0; ch_fsync = '0; fw_req = '0;
        axi_awready = 1'b1; axi_wready = 1'b1; axi_wlast = 1'b0; axi_bid = 4'd0;
        base[0] = 28'h0; base[1] = 28'h0; base[2] = 28'h100000;
        base[3] = 28'h300000; base[4] = 28'h400000;
        test_reset();
        test_single();
        test_back_pressure();
        test_fsync();
        test_async_reset();
        test_frame_wrap();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/axi_wr_arbiter_rr.md
Name: axi_wr_arbiter_rr

Overview:
- N-channel round-robin AXI write arbiter; generalises the fixed 5-source write interconnect into a parametrised block.
- Sits between the per-channel video_sampling line buffers and the DDR controller AXI write port.
- Grants one burst per request, fetches the burst from the granted channel's buffer and drives AW/W.
- Keeps a per-channel frame write pointer with frame-sync reset and frame-size wrap.

Parameters:
- CH_NUM, 5, number of source channels (1..8).
- CTRL_ADDR_WIDTH, 28, AXI address width.
- MEM_DQ_WIDTH, 32, DDR DQ width; AXI data width = MEM_DQ_WIDTH*8.
- BURST_LEN, 16, beats per burst (1..16); awlen = BURST_LEN-1.
- ADDR_STEP, 128, address increment per completed burst.
- FRAME_BURSTS, 1050, bursts per frame before the pointer wraps to base.
- BUF_AW, 10, channel buffer read-address width.

Ports:
- clk  in  1  system/AXI clock.
- rst_n  in  1  asynchronous active-low reset.
- ch_req  in  CH_NUM  per-channel level: a burst is available (data_out_ready).
- ch_fsync  in  CH_NUM  per-channel 1-cycle pulse, synchronised to clk: new frame.
- ch_base_addr  in  CH_NUM*CTRL_ADDR_WIDTH  packed per-channel frame base; ch k at [k*W +: W].
- ch_rd_data  in  CH_NUM*MEM_DQ_WIDTH*8  packed per-channel buffer read data; 1-cycle synchronous read.
- buf_rd_en  out  CH_NUM  one-hot read strobe to the granted buffer.
- buf_rd_addr  out  BUF_AW  buffer read address (beat index within the current burst slot).
- ch_done  out  CH_NUM  1-cycle pulse when the channel's burst completes.
- axi_awaddr  out  CTRL_ADDR_WIDTH
- axi_awid  out  4  = granted channel index.
- axi_awlen  out  4  = BURST_LEN-1.
- axi_awsize  out  3  = 3'b101.
- axi_awburst  out  2  = 2'b01.
- axi_awvalid  out  1
- axi_awready  in  1
- axi_wdata  out  MEM_DQ_WIDTH*8
- axi_wstrb  out  MEM_DQ_WIDTH  all ones.
- axi_wvalid  out  1
- axi_wready  in  1
- axi_wlast  in  1  asserted by the controller on the final accepted beat.
- axi_bid  in  4  unused; reserved.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0) forces:
  - state IDLE;
  - awvalid, wvalid, buf_rd_en, ch_done, busy = 0;
  - buf_rd_addr = 0; grant = 0; rr pointer = CH_NUM-1;
  - every wr_ptr[k] = ch_base_addr[k] and burst_cnt[k] = 0, applied on the first clk after release.
- Reset mid-burst abandons the burst; no ch_done pulse is produced.
- IDLE: if any ch_req bit is set, go to ARB.
- ARB (1 cycle): grant = first set ch_req bit searching from rr pointer+1 upward with wrap; rr pointer = grant. Go to AW.
- AW:
  - awvalid=1, awaddr = wr_ptr[grant], held stable until awready.
  - On awvalid&&awready: drop awvalid; buf_rd_en[grant]=1 with buf_rd_addr=0 (prefetch). Go to W.
- W:
  - wvalid=1 from the cycle after prefetch; wdata = ch_rd_data[grant] unregistered.
  - On each wvalid&&wready: beat_cnt++. If not the last beat, assert buf_rd_en with buf_rd_addr=beat_cnt+1 in the same cycle. The buffer output holds between reads, so wdata is stable while wready=0.
  - The last beat is the handshake with axi_wlast=1, or beat_cnt=BURST_LEN-1 (the internal count is authoritative).
  - On the last beat, go to DONE.
- DONE (1 cycle):
  - wvalid=0; ch_done[grant]=1.
  - wr_ptr[grant] += ADDR_STEP; burst_cnt[grant]++.
  - If burst_cnt reaches FRAME_BURSTS, wr_ptr = base and burst_cnt = 0.
  - Return to IDLE. A minimum of 2 idle cycles separates bursts.
- ch_fsync[k]: wr_ptr[k] = ch_base_addr[k] and burst_cnt[k] = 0 next cycle.
  - If channel k is granted and in AW/W, the reset is deferred to DONE and overrides the increment.
  - Fsync coinciding with DONE for channel k also yields base.
- ch_req deasserting after grant does not abort the burst.
- Address arithmetic is modulo 2^CTRL_ADDR_WIDTH; overflow wraps silently.
- Fairness: with all requests held high, grants cycle 0,1,...,CH_NUM-1,0.

Test Plan:
- Single channel: CH_NUM=5, ch_req=5'b00100, base2=0x100000, awready/wready always 1 -> awaddr 0x100000, awid 2, 16 beats, ch_done[2] pulses once; next burst awaddr 0x100080.
- Round robin: ch_req=5'b11111 held, 10 bursts -> awid sequence 0,1,2,3,4,0,1,2,3,4.
- Backpressure: wready toggles 1,0,0,1 per beat -> wdata equals buffer word n for beat n, no duplicates or skips, 16 handshakes total.
- Frame wrap: FRAME_BURSTS=3, ADDR_STEP=128, base0=0 -> awaddr 0,128,256,0.
- Fsync mid-burst: ch_fsync[1] during W of ch1 at wr_ptr 0x200 (base 0) -> that burst still writes 0x200; next ch1 awaddr = 0.
- Async reset during W: rst_n low for 3 cycles -> awvalid/wvalid drop immediately, no ch_done; after release all pointers at base, first grant goes to ch0.
